// File: rtl/roi_shift_host.sv
// Host side of a serial ROI shift chain: loads one N-bit word into the device
// MSB first, strobes it into din and captures the full-duplex return word.
module roi_shift_host #(
  parameter int N   = 256,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [N-1:0] tx_data,
  output logic         rx_valid,
  output logic [N-1:0] rx_data,
  output logic         rx_stale,
  output logic         di,
  output logic         stb,
  input  logic         do_i
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STROBE,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [N-1:0]  rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [1:0]    stale_cnt_q, stale_cnt_d;
  logic          rx_stale_q, rx_stale_d;
  logic          di_q, di_d;
  logic          stb_q, stb_d;

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, and tx_valid outside IDLE is simply ignored.
  assign tx_ready = (state_q == ST_IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_stale = rx_stale_q;
  assign di       = di_q;
  assign stb      = stb_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    stale_cnt_d = stale_cnt_q;
    rx_stale_d  = rx_stale_q;
    rx_valid_d  = 1'b0;
    di_d        = 1'b0;
    stb_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          di_d    = tx_data[N-1];
          // MSB leaves immediately on di; received bits fill in from the LSB.
          sr_d    = {tx_data[N-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        sr_d = {sr_q[N-2:0], do_i};
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_STROBE;
          stb_d      = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = {sr_q[N-2:0], do_i};
          rx_stale_d = (stale_cnt_q != 2'd2);
          if (stale_cnt_q != 2'd2) stale_cnt_d = stale_cnt_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          di_d  = sr_q[N-1];
        end
      end
      ST_STROBE: begin
        if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      sr_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      stale_cnt_q <= 2'd0;
      rx_stale_q  <= 1'b1;
      di_q        <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      stale_cnt_q <= stale_cnt_d;
      rx_stale_q  <= rx_stale_d;
      di_q        <= di_d;
      stb_q       <= stb_d;
    end
  end

endmodule

// File: tb/tb_roi_shift_host.sv
// Directed bench for roi_shift_host: one instance with GAP=0 wired to an ROI
// device model, one with GAP=3 for settle-time timing.
module tb_roi_shift_host;

  localparam int N = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         tx_valid0, tx_ready0, rx_valid0, rx_stale0, di0, stb0, do0;
  logic [N-1:0] tx_data0, rx_data0;
  logic         tx_valid3, tx_ready3, rx_valid3, rx_stale3, di3, stb3, do3;
  logic [N-1:0] tx_data3, rx_data3;

  assign do3 = 1'b1;

  roi_shift_host #(.N(N), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_data(tx_data0), .rx_valid(rx_valid0), .rx_data(rx_data0),
    .rx_stale(rx_stale0), .di(di0), .stb(stb0), .do_i(do0)
  );

  roi_shift_host #(.N(N), .GAP(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .tx_data(tx_data3), .rx_valid(rx_valid3), .rx_data(rx_data3),
    .rx_stale(rx_stale3), .di(di3), .stb(stb3), .do_i(do3)
  );

  // Device with identity roi: din captured on stb, output chain reloaded with
  // the previous din, giving the two-transaction return latency.
  logic [N-1:0] dev_in  = '0;
  logic [N-1:0] dev_din = '0;
  logic [N-1:0] dev_out = '0;
  always @(posedge clk) begin
    if (stb0) begin
      dev_din <= dev_in;
      dev_out <= dev_din;
    end else if (!tx_ready0) begin
      dev_in  <= {dev_in[N-2:0], di0};
      dev_out <= {dev_out[N-2:0], 1'b0};
    end
  end
  assign do0 = dev_out[N-1];

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk1({tag, "_di"}, di0, 1'b0);
    chk1({tag, "_stb"}, stb0, 1'b0);
    chk1({tag, "_rx_valid"}, rx_valid0, 1'b0);
    chkw({tag, "_rx_data"}, rx_data0, '0);
    chk1({tag, "_rx_stale"}, rx_stale0, 1'b1);
    chk1({tag, "_tx_ready"}, tx_ready0, 1'b1);
  endtask

  // Called and returns on a falling edge. tx_valid stays high with altered
  // tx_data during SHIFT; neither may disturb the latched word.
  task automatic xfer0(input logic [N-1:0] d, input logic [N-1:0] exp_rx,
                       input logic exp_stale, input bit check_rx);
    int guard;
    guard = 0;
    while (tx_ready0 !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk1("xfer0_ready_wait", tx_ready0, 1'b1);
    tx_data0  = d;
    tx_valid0 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == 0) tx_data0 = ~d;
      chk1("xfer0_di", di0, d[N-1-k]);
      if (k == 0 || k == N - 1) begin
        chk1("xfer0_busy", tx_ready0, 1'b0);
        chk1("xfer0_no_stb", stb0, 1'b0);
      end
    end
    @(negedge clk);
    tx_valid0 = 1'b0;
    chk1("strobe_stb", stb0, 1'b1);
    chk1("strobe_di", di0, 1'b0);
    chk1("strobe_rx_valid", rx_valid0, 1'b1);
    chk1("strobe_busy", tx_ready0, 1'b0);
    chk1("strobe_rx_stale", rx_stale0, exp_stale);
    if (check_rx) chkw("strobe_rx_data", rx_data0, exp_rx);
    @(negedge clk);
    chk1("after_ready", tx_ready0, 1'b1);
    chk1("after_stb", stb0, 1'b0);
    chk1("after_rx_valid", rx_valid0, 1'b0);
    chk1("after_di", di0, 1'b0);
    if (check_rx) chkw("after_rx_hold", rx_data0, exp_rx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] one_w, x_w, y_w, z_w, w_w, d3;
    int cnt;
    bit stb_seen;
    one_w = 1;
    x_w   = {32{8'hA5}};
    y_w   = {32{8'h0F}};
    z_w   = '1;
    w_w   = {16{16'h1234}};
    d3    = {32{8'h3C}};

    rst = 1'b1;
    tx_valid0 = 1'b0; tx_data0 = '0;
    tx_valid3 = 1'b0; tx_data3 = '0;
    repeat (2) @(negedge clk);
    chk_reset0("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset0("reset_release");
    chk1("reset_release_ready3", tx_ready3, 1'b1);
    chk1("reset_release_stb3", stb3, 1'b0);

    // Single low bit: di only in the last SHIFT cycle; device din becomes 1.
    xfer0(one_w, '0, 1'b1, 1'b1);
    chkw("dev_din_one", dev_din, one_w);

    // GAP=3 instance with tx_valid held high across two transfers.
    tx_data3  = d3;
    tx_valid3 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk1("gap3_di", di3, d3[N-1-k]);
    end
    @(negedge clk);
    chk1("gap3_stb", stb3, 1'b1);
    chk1("gap3_rx_valid", rx_valid3, 1'b1);
    chkw("gap3_rx_data", rx_data3, '1);
    chk1("gap3_rx_stale", rx_stale3, 1'b1);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk1("gap3_settle_stb", stb3, 1'b0);
      chk1("gap3_settle_busy", tx_ready3, 1'b0);
    end
    @(negedge clk);
    chk1("gap3_ready", tx_ready3, 1'b1);
    cnt = 0;
    while (stb3 !== 1'b1 && cnt < 2 * N) begin
      @(negedge clk);
      cnt++;
    end
    chki("gap3_period", cnt + 4, N + 5);
    tx_valid3 = 1'b0;
    chk1("gap3_second_stale", rx_stale3, 1'b1);
    repeat (4) @(negedge clk);
    chk1("gap3_idle_again", tx_ready3, 1'b1);

    // Reset clears the stale count; device contents persist across it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("pipe_stale_after_reset", rx_stale0, 1'b1);
    xfer0(x_w, '0, 1'b1, 1'b1);
    xfer0(y_w, one_w, 1'b1, 1'b1);
    xfer0(z_w, x_w, 1'b0, 1'b1);
    xfer0(w_w, y_w, 1'b0, 1'b1);
    chkw("dev_din_w", dev_din, w_w);

    // Reset in SHIFT cycle 100 aborts without a strobe.
    tx_data0  = y_w;
    tx_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid0 = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset0("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    stb_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (stb0 === 1'b1) stb_seen = 1'b1;
    end
    chk1("abort_no_stb", stb_seen, 1'b0);
    chk1("abort_idle", tx_ready0, 1'b1);
    xfer0(x_w, '0, 1'b1, 1'b0);
    xfer0(z_w, '0, 1'b1, 1'b0);
    xfer0(y_w, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
